// File: rtl/rc4_engine.sv
// RC4 decrypt engine: S-array init, key schedule, then PRGA decrypt of E ROM into D RAM.
// Latency: done pulses 1537 + 8*MSG_LEN cycles after start is accepted (DONE cycle included).
// Backpressure: none; start is sampled only in IDLE, and start while busy is dropped.
// Ports: clk/reset_n; start/key in, busy/done/ok out; S RAM (s_addr/s_wdata/s_wren/s_q),
//        E ROM (e_addr/e_q), D RAM (d_addr/d_wdata/d_wren). All memories have 1-cycle read latency.
// Optional: define RC4_ASCII_CHECK_EN to abort on the first decrypted byte outside a..z / space (ok=0).
module rc4_engine #(
  parameter int KEY_BYTES = 3,
  parameter int MSG_LEN   = 32,
  parameter int MSG_AW    = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic                   busy,
  output logic                   done,
  output logic                   ok,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wdata,
  output logic                   s_wren,
  input  logic [7:0]             s_q,
  output logic [MSG_AW-1:0]      e_addr,
  input  logic [7:0]             e_q,
  output logic [MSG_AW-1:0]      d_addr,
  output logic [7:0]             d_wdata,
  output logic                   d_wren
);

  localparam int             KBW     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KBW-1:0] KB_LAST = KBW'(KEY_BYTES - 1);
  localparam logic [8:0]     K_LAST  = 9'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, INIT,
    K_RDI, K_RDJ, K_CAPJ, K_WRI, K_WRJ,
    P_RDI, P_RDJ, P_CAPJ, P_WRI, P_WRJ, P_RDF, P_CAPF, P_WRD,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             i_q, i_d, j_q, j_d;
  logic [7:0]             si_q, si_d, sj_q, sj_d;
  logic [7:0]             fe_q, fe_d;       // keystream byte XOR cipher byte
  logic [8:0]             k_q, k_d;         // 9 bits so MSG_LEN=256 terminates cleanly
  logic [KBW-1:0]         kb_q, kb_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [7:0]             key_byte;

  // Byte kb of the key; byte 0 sits in the most significant position.
  assign key_byte = 8'(key_q >> (8 * (KEY_BYTES - 1 - int'(kb_q))));

`ifdef RC4_ASCII_CHECK_EN
  logic ok_q, ok_d;

  function automatic logic is_text(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  assign ok = (state_q == DONE) && ok_q;
`else
  assign ok = (state_q == DONE);
`endif

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    fe_d    = fe_q;
    k_d     = k_q;
    kb_d    = kb_q;
    key_d   = key_q;
`ifdef RC4_ASCII_CHECK_EN
    ok_d    = ok_q;
`endif
    s_addr  = 8'h00;
    s_wdata = 8'h00;
    s_wren  = 1'b0;
    e_addr  = '0;
    d_addr  = '0;
    d_wdata = 8'h00;
    d_wren  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INIT;
          key_d   = key;
          i_d     = 8'h00;
          j_d     = 8'h00;
          k_d     = 9'h000;
          kb_d    = '0;
`ifdef RC4_ASCII_CHECK_EN
          ok_d    = 1'b1;
`endif
        end
      end
      INIT: begin
        s_addr  = i_q;
        s_wdata = i_q;
        s_wren  = 1'b1;
        i_d     = i_q + 8'd1;           // wraps to 0 for the key schedule
        if (i_q == 8'hFF) state_d = K_RDI;
      end
      K_RDI: begin
        s_addr  = i_q;
        state_d = K_RDJ;
      end
      K_RDJ: begin
        // s_q carries S[i] this cycle; the new j is used as read address straight away.
        si_d    = s_q;
        j_d     = j_q + s_q + key_byte;
        s_addr  = j_d;
        state_d = K_CAPJ;
      end
      K_CAPJ: begin
        sj_d    = s_q;
        state_d = K_WRI;
      end
      K_WRI: begin
        s_addr  = i_q;
        s_wdata = sj_q;
        s_wren  = 1'b1;
        state_d = K_WRJ;
      end
      K_WRJ: begin
        // Writing S[j] last keeps i==j correct: both writes carry the same value.
        s_addr  = j_q;
        s_wdata = si_q;
        s_wren  = 1'b1;
        i_d     = i_q + 8'd1;
        kb_d    = (kb_q == KB_LAST) ? '0 : kb_q + 1'b1;
        if (i_q == 8'hFF) begin
          state_d = P_RDI;
          j_d     = 8'h00;
          k_d     = 9'h000;
        end else begin
          state_d = K_RDI;
        end
      end
      P_RDI: begin
        i_d     = i_q + 8'd1;
        s_addr  = i_d;
        state_d = P_RDJ;
      end
      P_RDJ: begin
        si_d    = s_q;
        j_d     = j_q + s_q;
        s_addr  = j_d;
        state_d = P_CAPJ;
      end
      P_CAPJ: begin
        sj_d    = s_q;
        state_d = P_WRI;
      end
      P_WRI: begin
        s_addr  = i_q;
        s_wdata = sj_q;
        s_wren  = 1'b1;
        state_d = P_WRJ;
      end
      P_WRJ: begin
        s_addr  = j_q;
        s_wdata = si_q;
        s_wren  = 1'b1;
        state_d = P_RDF;
      end
      P_RDF: begin
        s_addr  = si_q + sj_q;
        e_addr  = k_q[MSG_AW-1:0];
        state_d = P_CAPF;
      end
      P_CAPF: begin
        fe_d    = s_q ^ e_q;
        state_d = P_WRD;
      end
      P_WRD: begin
        d_addr  = k_q[MSG_AW-1:0];
        d_wdata = fe_q;
        d_wren  = 1'b1;
        k_d     = k_q + 9'd1;
        state_d = (k_q == K_LAST) ? DONE : P_RDI;
`ifdef RC4_ASCII_CHECK_EN
        if (!is_text(fe_q)) begin
          ok_d    = 1'b0;
          state_d = DONE;
        end
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      i_q     <= 8'h00;
      j_q     <= 8'h00;
      si_q    <= 8'h00;
      sj_q    <= 8'h00;
      fe_q    <= 8'h00;
      k_q     <= 9'h000;
      kb_q    <= '0;
      key_q   <= '0;
`ifdef RC4_ASCII_CHECK_EN
      ok_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      fe_q    <= fe_d;
      k_q     <= k_d;
      kb_q    <= kb_d;
      key_q   <= key_d;
`ifdef RC4_ASCII_CHECK_EN
      ok_q    <= ok_d;
`endif
    end
  end

endmodule

// File: tb/tb_rc4_engine.sv
// Bench for rc4_engine: two instances (4-byte key / 5-byte message, 3-byte key / 9-byte message)
// with behavioural S RAM, E ROM and D RAM; known vectors from a table, random runs vs an RC4 model.
module tb_rc4_engine;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cur_run = 0;

  // ---------------- instance A: KEY_BYTES=4, MSG_LEN=5 ----------------
  logic        start_a, busy_a, done_a, ok_a, s_wren_a, d_wren_a;
  logic [31:0] key_a;
  logic [7:0]  s_addr_a, s_wdata_a, s_q_a, e_q_a, d_wdata_a;
  logic [2:0]  e_addr_a, d_addr_a;
  logic [7:0]  s_mem_a [256];
  logic [7:0]  e_mem_a [8];
  logic [7:0]  d_mem_a [8];
  int          d_gen_a [8];
  logic [7:0]  s_aq_a;
  logic [2:0]  e_aq_a;

  rc4_engine #(.KEY_BYTES(4), .MSG_LEN(5), .MSG_AW(3)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .key(key_a),
    .busy(busy_a), .done(done_a), .ok(ok_a),
    .s_addr(s_addr_a), .s_wdata(s_wdata_a), .s_wren(s_wren_a), .s_q(s_q_a),
    .e_addr(e_addr_a), .e_q(e_q_a),
    .d_addr(d_addr_a), .d_wdata(d_wdata_a), .d_wren(d_wren_a)
  );

  always @(posedge clk) begin
    if (s_wren_a) s_mem_a[s_addr_a] <= s_wdata_a;
    if (d_wren_a) begin
      d_mem_a[d_addr_a] <= d_wdata_a;
      d_gen_a[d_addr_a] <= cur_run;
    end
    s_aq_a <= s_addr_a;
    e_aq_a <= e_addr_a;
  end
  assign s_q_a = s_mem_a[s_aq_a];
  assign e_q_a = e_mem_a[e_aq_a];

  // ---------------- instance B: KEY_BYTES=3, MSG_LEN=9 ----------------
  logic        start_b, busy_b, done_b, ok_b, s_wren_b, d_wren_b;
  logic [23:0] key_b;
  logic [7:0]  s_addr_b, s_wdata_b, s_q_b, e_q_b, d_wdata_b;
  logic [3:0]  e_addr_b, d_addr_b;
  logic [7:0]  s_mem_b [256];
  logic [7:0]  e_mem_b [16];
  logic [7:0]  d_mem_b [16];
  int          d_gen_b [16];
  logic [7:0]  s_aq_b;
  logic [3:0]  e_aq_b;

  rc4_engine #(.KEY_BYTES(3), .MSG_LEN(9), .MSG_AW(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .key(key_b),
    .busy(busy_b), .done(done_b), .ok(ok_b),
    .s_addr(s_addr_b), .s_wdata(s_wdata_b), .s_wren(s_wren_b), .s_q(s_q_b),
    .e_addr(e_addr_b), .e_q(e_q_b),
    .d_addr(d_addr_b), .d_wdata(d_wdata_b), .d_wren(d_wren_b)
  );

  always @(posedge clk) begin
    if (s_wren_b) s_mem_b[s_addr_b] <= s_wdata_b;
    if (d_wren_b) begin
      d_mem_b[d_addr_b] <= d_wdata_b;
      d_gen_b[d_addr_b] <= cur_run;
    end
    s_aq_b <= s_addr_b;
    e_aq_b <= e_addr_b;
  end
  assign s_q_b = s_mem_b[s_aq_b];
  assign e_q_b = e_mem_b[e_aq_b];

  // ---------------- reference model and helpers ----------------
  logic [7:0] ks_ref [256];
  logic [7:0] exp_d  [16];
  logic [7:0] e_buf  [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Plain RC4 keystream for a key of kl bytes (byte 0 = most significant byte of k).
  task automatic rc4_model(input logic [31:0] k, input int kl, input int n);
    int s [256];
    int kk [4];
    int i, j, t;
    for (int b = 0; b < kl; b++) kk[b] = int'(8'(k >> (8 * (kl - 1 - b))));
    for (int a = 0; a < 256; a++) s[a] = a;
    j = 0;
    for (int a = 0; a < 256; a++) begin
      j = (j + s[a] + kk[a % kl]) % 256;
      t = s[a]; s[a] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int m = 0; m < n; m++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      ks_ref[m] = 8'(s[(s[i] + s[j]) % 256]);
    end
  endtask

  function automatic bit is_text(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  function automatic logic [7:0] byte_of(input logic [71:0] v, input int x);
    return 8'(v >> (8 * (8 - x)));
  endfunction

  task automatic load_e(input int sel, input int len);
    for (int x = 0; x < len; x++) begin
      if (sel == 0) e_mem_a[x] = e_buf[x];
      else          e_mem_b[x] = e_buf[x];
    end
  endtask

  // One complete run on instance sel; exp_d holds the plaintext expected in D.
  task automatic run(input int sel, input logic [31:0] k, input int len, input bit hold,
                     input bit chk_init, output int lat, output bit okv);
    int n, sw, dw, coll, gap, nexp, bad;
    bit got, okx, bsy, dn, swr, dwr, okk;
    logic [15:0] dval;
    nexp = len;
    okx  = 1'b1;
`ifdef RC4_ASCII_CHECK_EN
    for (int x = 0; x < len; x++) begin
      if (okx && !is_text(exp_d[x])) begin
        okx  = 1'b0;
        nexp = x + 1;
      end
    end
`endif
    cur_run++;
    @(negedge clk);
    if (sel == 0) begin key_a = k; start_a = 1'b1; end
    else          begin key_b = k[23:0]; start_b = 1'b1; end
    n = 0; sw = 0; dw = 0; coll = 0; gap = 0; got = 1'b0; lat = -1; okv = 1'b0;
    while (!got && n < 4000) begin
      @(negedge clk);
      if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
      n++;
      bsy = (sel == 0) ? busy_a   : busy_b;
      dn  = (sel == 0) ? done_a   : done_b;
      okk = (sel == 0) ? ok_a     : ok_b;
      swr = (sel == 0) ? s_wren_a : s_wren_b;
      dwr = (sel == 0) ? d_wren_a : d_wren_b;
      if (swr) sw++;
      if (dwr) dw++;
      if (swr && dwr) coll++;
      if (!bsy) gap++;
      if (chk_init && n == 257) begin
        bad = 0;
        for (int a = 0; a < 256; a++)
          if (((sel == 0) ? s_mem_a[a] : s_mem_b[a]) !== 8'(a)) bad++;
        chk("init_wren_count", sw, 256);
        chk("init_s_identity_bad", bad, 0);
      end
      if (dn) begin got = 1'b1; lat = n; okv = okk; end
    end
    chk("done_seen", 32'(got), 1);
    if (hold) begin
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      @(negedge clk);
      chk("start_in_done_ignored", 32'((sel == 0) ? busy_a : busy_b), 0);
    end
    chk("latency", lat, 1537 + 8 * nexp);
    chk("ok", 32'(okv), 32'(okx));
    chk("s_wren_count", sw, 768 + 2 * nexp);
    chk("d_wren_count", dw, nexp);
    chk("write_collisions", coll, 0);
    chk("busy_gaps", gap, 0);
    for (int x = 0; x < len; x++) begin
      if (sel == 0) dval = (d_gen_a[x] == cur_run) ? {8'h00, d_mem_a[x]} : 16'hDEAD;
      else          dval = (d_gen_b[x] == cur_run) ? {8'h00, d_mem_b[x]} : 16'hDEAD;
      chk($sformatf("d_byte[%0d]", x), 32'(dval), (x < nexp) ? {24'h0, exp_d[x]} : 32'hDEAD);
    end
  endtask

  typedef struct packed {
    int          sel;
    int          kl;
    logic [31:0] key;
    int          len;
    logic [71:0] e;
    logic [71:0] d;
    logic        ok;
    int          lat;
  } vec_t;

  initial begin
    vec_t tbl [2];
    int lat, bad, sel, kl, len;
    bit okv;
    logic [31:0] k;
    logic [7:0] p;

    tbl[0] = '{sel: 0, kl: 4, key: 32'h57696B69, len: 5,
               e: 72'h1021BF0420_00000000, d: 72'h7065646961_00000000, ok: 1'b1, lat: 1577};
`ifdef RC4_ASCII_CHECK_EN
    tbl[1] = '{sel: 1, kl: 3, key: 32'h004B6579, len: 9,
               e: 72'hBBF316E8D940AF0AD3, d: 72'h506C61696E74657874, ok: 1'b0, lat: 1545};
`else
    tbl[1] = '{sel: 1, kl: 3, key: 32'h004B6579, len: 9,
               e: 72'hBBF316E8D940AF0AD3, d: 72'h506C61696E74657874, ok: 1'b1, lat: 1609};
`endif

    reset_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    key_a = '0; key_b = '0;
    #1;
    chk("reset_outputs_a", {busy_a, done_a, ok_a, s_wren_a, d_wren_a, s_addr_a, e_addr_a, d_addr_a}, 0);
    chk("reset_outputs_b", {busy_b, done_b, ok_b, s_wren_b, d_wren_b, s_addr_b, e_addr_b, d_addr_b}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Known vectors.
    for (int v = 0; v < 2; v++) begin
      len = tbl[v].len;
      bad = 0;
      rc4_model(tbl[v].key, tbl[v].kl, len);
      for (int x = 0; x < len; x++) begin
        exp_d[x] = byte_of(tbl[v].d, x);
        e_buf[x] = byte_of(tbl[v].e, x);
        if ((ks_ref[x] ^ e_buf[x]) !== exp_d[x]) bad++;
      end
      chk("model_vs_vector_bad", bad, 0);
      load_e(tbl[v].sel, len);
      run(tbl[v].sel, tbl[v].key, len, 1'b0, v == 0, lat, okv);
      chk("vec_latency", lat, tbl[v].lat);
      chk("vec_ok", 32'(okv), 32'(tbl[v].ok));
    end

    // Reset in the middle of the key schedule, then a clean rerun of vector 0.
    @(negedge clk);
    key_a = tbl[0].key; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (600) @(negedge clk);
    chk("ksa_busy_before_reset", 32'(busy_a), 1);
    reset_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", {busy_a, done_a, ok_a, s_wren_a, d_wren_a, s_addr_a, e_addr_a, d_addr_a}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy_a, s_wren_a}, 0);
    for (int x = 0; x < 5; x++) begin
      exp_d[x] = byte_of(tbl[0].d, x);
      e_buf[x] = byte_of(tbl[0].e, x);
    end
    load_e(0, 5);
    run(0, tbl[0].key, 5, 1'b0, 1'b1, lat, okv);

    // Random keys and plaintexts, back to back; run 1 holds start high throughout,
    // run 3 carries an upper-case byte that the text check rejects.
    for (int r = 0; r < 6; r++) begin
      sel = r % 2;
      kl  = (sel == 0) ? 4 : 3;
      len = (sel == 0) ? 5 : 9;
      k   = $urandom;
      if (sel == 1) k = k & 32'h00FF_FFFF;
      for (int x = 0; x < len; x++) begin
        if ($urandom_range(0, 7) == 0) p = 8'h20;
        else p = 8'h61 + 8'($urandom_range(0, 25));
        if (r == 3 && x == 2) p = 8'h41;
        exp_d[x] = p;
      end
      rc4_model(k, kl, len);
      for (int x = 0; x < len; x++) e_buf[x] = exp_d[x] ^ ks_ref[x];
      load_e(sel, len);
      run(sel, k, len, r == 1, 1'b0, lat, okv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rc4_engine.md
Name: rc4_engine

Overview:
- Self-contained RC4 decrypt engine, parametrised in key length and message length.
- Sequences the three phases in one FSM:
  - S-array init (S[i]=i).
  - Key schedule.
  - PRGA decrypt of an encrypted ROM into a decrypted RAM.
- Drives external single-port S RAM, E ROM and D RAM; start/done handshake for use by a key-search controller.
- Successor to the fixed 3-byte, switch-keyed task chain, which used separate per-phase FSMs and a top-level mux.

Parameters:
- KEY_BYTES, 3, key length in bytes (1..32).
- MSG_LEN, 32, message length in bytes (1..256).
- MSG_AW, 5, width of E/D address ports; must satisfy 2^MSG_AW >= MSG_LEN.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- key  in  8*KEY_BYTES  secret key; byte 0 = key[8*KEY_BYTES-1 -: 8]; latched when start is accepted.
- busy  out  1  high from start acceptance through the DONE cycle.
- done  out  1  one-cycle pulse at completion.
- ok  out  1  result valid flag; meaningful in the done cycle.
- s_addr  out  8  S RAM address.
- s_wdata  out  8  S RAM write data.
- s_wren  out  1  S RAM write enable.
- s_q  in  8  S RAM read data.
- e_addr  out  MSG_AW  E ROM address.
- e_q  in  8  E ROM read data.
- d_addr  out  MSG_AW  D RAM address.
- d_wdata  out  8  D RAM write data.
- d_wren  out  1  D RAM write enable.

Behaviour:
- Memory timing: all memories have registered address and 1-cycle read latency. An address driven in cycle N gives q sampleable at the end of cycle N+1.
- Reset: FSM goes to IDLE. busy=0, done=0, ok=0, all wren=0, all addresses=0, i=j=k=0. Reset mid-operation aborts immediately; memory contents are undefined afterwards.
- IDLE → INIT on start. start while busy is ignored.
- INIT (256 cycles):
  - Cycle n: s_addr=n, s_wdata=n, s_wren=1.
  - After n=255, go to KSA with i=0, j=0, key index kb=0.
- KSA, 5 cycles per i (1280 cycles total):
  - K_RDI: s_addr=i.
  - K_RDJ: si=s_q; j=j+si+key[kb] (mod 256); s_addr=new j.
  - K_CAPJ: sj=s_q.
  - K_WRI: S[i]=sj.
  - K_WRJ: S[j]=si; i++; kb wraps to 0 at KEY_BYTES-1.
  - After i=255, go to PRGA with i=0, j=0, k=0.
- PRGA, 8 cycles per byte k:
  - P_RDI: i=i+1; s_addr=i+1.
  - P_RDJ: si=s_q; j=j+si; s_addr=new j.
  - P_CAPJ: sj=s_q.
  - P_WRI: S[i]=sj.
  - P_WRJ: S[j]=si.
  - P_RDF: s_addr=si+sj (mod 256); e_addr=k.
  - P_CAPF: f=s_q; e=e_q.
  - P_WRD: d_addr=k, d_wdata=f^e, d_wren=1; k++.
  - After k=MSG_LEN-1, go to DONE.
- DONE (1 cycle): done=1, busy=1, ok per feature. Next state is IDLE.
- Latency: done asserts exactly 1537+8*MSG_LEN cycles after the start-sample cycle, counting the DONE cycle.
- Write enables are high only in their write states; no two memories are written in the same cycle.
- Index arithmetic is 8-bit wrap-around. kb and k are counters; no divider is used.
- i==j: the swap writes the same value twice; the result must be unchanged from a correct serial swap.

Optional Feature:
- Macro: RC4_ASCII_CHECK_EN.
- Defined:
  - In P_WRD, each f^e is checked against 0x61..0x7A or 0x20.
  - On the first failing byte, the write still occurs, then the FSM goes straight to DONE with ok=0 (early abort).
  - If all bytes pass, ok=1.
- Undefined: no checking; ok=1 in every done cycle.

Test Plan:
- Reset mid-KSA: assert reset_n=0 during the KSA phase → next cycle busy=0, s_wren=0, FSM in IDLE. A subsequent start runs to completion.
- Known vector: KEY_BYTES=4, MSG_LEN=5, key=0x57696B69 ("Wiki"), E=10 21 BF 04 20 → D="pedia" (70 65 64 69 61), ok=1. done at cycle 1577 after start.
- Known vector: KEY_BYTES=3, MSG_LEN=9, key=0x4B6579 ("Key"), E=BB F3 16 E8 D9 40 AF 0A D3 → D=50 6C 61 69 6E 74 65 78 74.
  - Macro undefined: ok=1, done at cycle 1609.
  - Macro defined: abort after k=0 (0x50 fails), ok=0, done at cycle 1545.
- Init check: after INIT, read back the S model → S[n]=n for all 256 entries; exactly 256 s_wren cycles.
- start asserted during busy, and start held high across done → ignored while busy. A new run begins only from IDLE; two back-to-back runs with different keys both produce correct D.
